// File: rtl/fb_write_ctrl.sv
// ============================================================================
// Module      : fb_write_ctrl
// Description : Back-buffer write controller for a double-buffered 320x240,
//               3-bit RGB frame store. Clears the back buffer, accepts
//               rasterizer pixel writes, then requests a swap (DRAW_DONE) and
//               waits for the display side to confirm it (frame_switched).
// Ports       : Clk / Reset_N                  clock, async active-low reset
//               px_valid/px_ready/px_x/px_y/px_color/frame_end  rasterizer
//               px_drop, frame_start           status pulses
//               back_sel, DRAW_DONE, frame_switched  swap handshake
//               BUFFERn_WR/_WR_CLK/_DATA/_ADDR  buffer write ports
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_write_ctrl #(
    parameter int         WIDTH       = 320,
    parameter int         HEIGHT      = 240,
    parameter int         ADDR_W      = 17,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              px_valid,
    output logic              px_ready,
    input  logic [8:0]        px_x,
    input  logic [7:0]        px_y,
    input  logic [2:0]        px_color,
    input  logic              frame_end,
    output logic              px_drop,
    output logic              frame_start,
    output logic              back_sel,
    output logic              DRAW_DONE,
    input  logic              frame_switched,
    output logic              BUFFER1_WR,
    output logic              BUFFER2_WR,
    output logic              BUFFER1_WR_CLK,
    output logic              BUFFER2_WR_CLK,
    output logic [2:0]        BUFFER1_DATA,
    output logic [2:0]        BUFFER2_DATA,
    output logic [ADDR_W-1:0] BUFFER1_ADDR,
    output logic [ADDR_W-1:0] BUFFER2_ADDR
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_CLEAR     = 2'd0,
        S_DRAW      = 2'd1,
        S_WAIT_SWAP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_back_sel;
    logic                r_draw_done;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_data;
    logic                r_drop;
    logic                r_fs_meta;
    logic                r_fs_sync;
    logic                r_fs_prev;

    logic                w_clear_last;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_px_addr;
    logic                w_fs_rise;
    logic                w_swap;

    // y*320 + x as shift-add; the maximum (76799) fits in 17 bits.
    assign w_px_addr  = ADDR_W'({px_y, 8'b0}) + ADDR_W'({px_y, 6'b0}) + ADDR_W'(px_x);
    assign w_in_range = ({23'd0, px_x} < 32'(WIDTH)) && ({24'd0, px_y} < 32'(HEIGHT));

    // Only a synchronized 0->1 edge counts. Requiring DRAW_DONE to already be
    // high means an edge that started before the swap request was visible
    // (i.e. a level that was already high on entry) cannot complete the swap.
    assign w_fs_rise = r_fs_sync & ~r_fs_prev;
    assign w_swap    = (r_state == S_WAIT_SWAP) && r_draw_done && w_fs_rise;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_clear_last = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == C_LAST_ADDR) begin
                    w_clear_last = 1'b1;
                    w_next_state = S_DRAW;
                end
            end
            S_DRAW: begin
                if (frame_end) begin
                    w_next_state = S_WAIT_SWAP;
                end
            end
            S_WAIT_SWAP: begin
                if (w_swap) begin
                    w_next_state = S_CLEAR;
                end
            end
            default: w_next_state = S_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: clear counter, registered write port, swap handshake
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_clr_addr  <= '0;
            r_back_sel  <= 1'b1;   // display starts on BUFFER1
            r_draw_done <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data      <= 3'b000;
            r_drop      <= 1'b0;
            r_fs_meta   <= 1'b0;
            r_fs_sync   <= 1'b0;
            r_fs_prev   <= 1'b0;
        end else begin
            r_fs_meta <= frame_switched;
            r_fs_sync <= r_fs_meta;
            r_fs_prev <= r_fs_sync;

            r_wr   <= 1'b0;
            r_drop <= 1'b0;
            // Raised one cycle after entering WAIT_SWAP so the final pixel
            // strobe is already on the bus before the swap is requested.
            r_draw_done <= (r_state == S_WAIT_SWAP) && !w_swap;

            case (r_state)
                S_CLEAR: begin
                    r_wr   <= 1'b1;
                    r_addr <= r_clr_addr;
                    r_data <= CLEAR_COLOR;
                    if (!w_clear_last) begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (px_valid) begin
                        if (w_in_range) begin
                            r_wr   <= 1'b1;
                            r_addr <= w_px_addr;
                            r_data <= px_color;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_WAIT_SWAP: begin
                    if (w_swap) begin
                        r_back_sel <= ~r_back_sel;
                        r_clr_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. back_sel never changes while a write is in flight, so it
    // can steer the shared write strobe directly.
    // ------------------------------------------------------------------
    assign px_ready       = (r_state == S_DRAW);
    assign frame_start    = w_clear_last;
    assign px_drop        = r_drop;
    assign back_sel       = r_back_sel;
    assign DRAW_DONE      = r_draw_done;

    assign BUFFER1_WR     = r_wr & ~r_back_sel;
    assign BUFFER2_WR     = r_wr &  r_back_sel;
    assign BUFFER1_WR_CLK = Clk;
    assign BUFFER2_WR_CLK = Clk;
    assign BUFFER1_DATA   = r_data;
    assign BUFFER2_DATA   = r_data;
    assign BUFFER1_ADDR   = r_addr;
    assign BUFFER2_ADDR   = r_addr;

endmodule

`default_nettype wire

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Back-buffer write controller for the double-buffered 320x240, 3-bit RGB display path. It sits directly upstream of the display output stage. It clears the current back buffer, then accepts pixel writes from the rasterizer over a valid/ready handshake. When the rasterizer signals end of frame, it raises DRAW_DONE and holds it until the display side reports the buffer swap through frame_switched. The back buffer then toggles and the cycle repeats.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_W, 17, buffer address width
- CLEAR_COLOR, 3'b000, {r,g,b} written during clear
- Clk  in  1  system clock (50 MHz). One clock; all logic is on its rising edge.
- Reset_N  in  1  reset, asynchronous, active-low
- px_valid  in  1  rasterizer pixel valid
- px_ready  out  1  controller accepts pixel
- px_x  in  9  pixel column
- px_y  in  8  pixel row
- px_color  in  3  {r,g,b}
- frame_end  in  1  rasterizer frame complete; sampled with px_valid&px_ready semantics, see Operation
- px_drop  out  1  one-cycle pulse: an accepted pixel was out of range
- frame_start  out  1  one-cycle pulse: clear finished, drawing may begin
- back_sel  out  1  0 = BUFFER1 is back buffer, 1 = BUFFER2
- DRAW_DONE  out  1  back buffer complete, request swap
- frame_switched  in  1  asynchronous level from display stage
- BUFFER1_WR, BUFFER2_WR  out  1  write strobes
- BUFFER1_WR_CLK, BUFFER2_WR_CLK  out  1  tied to Clk
- BUFFER1_DATA, BUFFER2_DATA  out  3  write data (same value on both)
- BUFFER1_ADDR, BUFFER2_ADDR  out  17  write address (same value on both)

## Operation
- States: CLEAR, DRAW, WAIT_SWAP. Reset enters CLEAR with clr_addr=0 and back_sel=1, because the display starts on BUFFER1.
- CLEAR:
  - One write per cycle of CLEAR_COLOR at clr_addr to the back buffer. px_ready=0.
  - clr_addr counts 0..WIDTH*HEIGHT-1 (76799). After issuing 76799, go to DRAW and pulse frame_start for one cycle.
- DRAW:
  - px_ready=1. A pixel is accepted when px_valid&px_ready.
  - Address = px_y*320+px_x, computed as (y<<8)+(y<<6)+x in 17 bits; maximum 76799, no overflow.
  - If px_x>=WIDTH or px_y>=HEIGHT: no write; px_drop pulses.
  - frame_end is honoured only in DRAW. If it arrives with px_valid in the same cycle, the pixel is written first, then the block goes to WAIT_SWAP.
  - frame_end outside DRAW is ignored.
- WAIT_SWAP:
  - px_ready=0 and DRAW_DONE=1.
  - frame_switched passes through a 2-flop synchronizer plus an edge register.
  - On the synchronized rising edge: back_sel toggles, DRAW_DONE clears, clr_addr goes to 0, and the state goes to CLEAR.
  - A frame_switched level that is already high on entry does not count; only a 0->1 edge counts.
- Only the back buffer's WR is ever asserted. The front buffer's WR stays 0 in every state.

## Timing
- Reset values:
  - px_ready=0, px_drop=0, frame_start=0, DRAW_DONE=0, back_sel=1.
  - All WR=0, all ADDR=0, all DATA=0.
  - Synchronizer flops=0.
- Write path is registered:
  - A pixel accepted at edge N drives ADDR/DATA/WR on cycle N+1.
  - The clear write for clr_addr=k appears one cycle after the counter holds k.
- CLEAR lasts exactly 76800 write cycles. The first pixel can be accepted on the cycle after frame_start.
- frame_end accepted at edge N:
  - Final pixel write strobe on cycle N+1.
  - DRAW_DONE=1 from cycle N+2, so all writes are committed before the request.
- Swap latency: DRAW_DONE falls and back_sel toggles 3 cycles after the frame_switched rising edge.
  - The display stage samples DRAW_DONE once per vsync. It must not see DRAW_DONE high on two consecutive vsyncs; the 3-cycle latency is far below one frame period, which guarantees this.
- Reset mid-operation, in any state: every output returns to its reset value immediately, and a full clear restarts. The display stage must be reset on the same system reset.

## Test plan
- Reset, then run: exactly 76800 BUFFER2_WR pulses with ADDR 0..76799 and DATA=000. BUFFER1_WR stays 0 throughout. frame_start pulses once, and px_ready=1 on the next cycle.
- Pixel write: px_x=5, px_y=2, px_color=3'b101 accepted -> next cycle BUFFER2_WR=1, ADDR=645, DATA=101. Also px_x=319, px_y=239 -> ADDR=76799.
- Out of range: px_x=320, px_y=0 -> no WR and px_drop=1 for one cycle. Same response for px_y=240.
- Swap handshake:
  - Pixel and frame_end in the same cycle: pixel written, DRAW_DONE high 2 cycles after acceptance, px_ready=0.
  - Raise frame_switched: 3 cycles later DRAW_DONE=0, back_sel=0, and the clear now strobes BUFFER1_WR only.
- frame_switched held high before entering WAIT_SWAP: no swap occurs until it goes low and rises again.
- Async reset mid-clear at clr_addr=1000 and mid-WAIT_SWAP: outputs reset immediately (back_sel=1, DRAW_DONE=0), and the clear restarts from ADDR 0.
